// File: rtl/algorithm_multi_vc_if.sv
// Handshake bundle for the multi-VC XY routing stage: one AXI-Stream input and
// CHANNEL_NUMBER per-channel outputs with reservation release and routing sideband.
interface algorithm_multi_vc_if #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned ID_WIDTH            = 4,
  parameter int unsigned DEST_WIDTH          = 4,
  parameter int unsigned USER_WIDTH          = 4,
  parameter int unsigned VC_NUM              = 2,
  parameter int unsigned VC_WIDTH            = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int unsigned CHANNEL_NUMBER      = 5 * VC_NUM,
  parameter int unsigned MAX_ROUTERS_X       = 4,
  parameter int unsigned MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
  parameter int unsigned MAX_ROUTERS_Y       = 4,
  parameter int unsigned MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y)
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } axis_data_t;

  axis_data_t                     in;
  logic                           in_valid;
  logic                           in_ready;
  axis_data_t                     out [CHANNEL_NUMBER];
  logic [CHANNEL_NUMBER-1:0]      out_valid;
  logic [CHANNEL_NUMBER-1:0]      out_ready;
  logic [CHANNEL_NUMBER-1:0]      out_release;
  logic [VC_WIDTH-1:0]            vc_req;
  logic [MAX_ROUTERS_X_WIDTH-1:0] target_x;
  logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y;
  logic [CHANNEL_NUMBER-1:0]      busy;
  logic                           err_drop;

  modport master (
    output in, in_valid, out_ready, out_release, vc_req, target_x, target_y,
    input  in_ready, out, out_valid, busy, err_drop
  );

  modport slave (
    input  in, in_valid, out_ready, out_release, vc_req, target_x, target_y,
    output in_ready, out, out_valid, busy, err_drop
  );
endinterface

// File: rtl/algorithm_multi_vc.sv
// XY-routing stage steering one AXI-Stream input onto 5 directions x VC_NUM virtual
// channels; the chosen channel is locked per packet and stays reserved until released.
module algorithm_multi_vc #(
  parameter int unsigned       DATA_WIDTH           = 32,
  parameter int unsigned       ID_WIDTH             = 4,
  parameter int unsigned       DEST_WIDTH           = 4,
  parameter int unsigned       USER_WIDTH           = 4,
  parameter int unsigned       VC_NUM               = 2,
  parameter int unsigned       VC_WIDTH             = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int unsigned       CHANNEL_NUMBER       = 5 * VC_NUM,
  parameter int unsigned       CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int unsigned       VC_MODE              = 0,
  parameter int unsigned       MAX_ROUTERS_X        = 4,
  parameter int unsigned       MAX_ROUTERS_X_WIDTH  = $clog2(MAX_ROUTERS_X),
  parameter int unsigned       MAX_ROUTERS_Y        = 4,
  parameter int unsigned       MAX_ROUTERS_Y_WIDTH  = $clog2(MAX_ROUTERS_Y),
  parameter int unsigned       ROUTER_X             = 0,
  parameter int unsigned       ROUTER_Y             = 0,
  parameter logic [ID_WIDTH-1:0] ROUTING_HEADER     = '1
) (
  input logic                 clk,
  input logic                 rst,
  algorithm_multi_vc_if.slave bus
);
  localparam int unsigned BeatBits = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
  localparam logic [CHANNEL_NUMBER-1:0] ChanOne = CHANNEL_NUMBER'(1);

  localparam logic [2:0] DirLocal = 3'd0;
  localparam logic [2:0] DirNorth = 3'd1;
  localparam logic [2:0] DirEast  = 3'd2;
  localparam logic [2:0] DirSouth = 3'd3;
  localparam logic [2:0] DirWest  = 3'd4;

  typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

  state_e                          state_q, state_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] sel_q, sel_d, cand;
  logic [CHANNEL_NUMBER-1:0]       busy_q, busy_set, cand_oh, sel_oh, out_valid_c;
  logic [BeatBits-1:0]             in_bits;
  logic [BeatBits-1:0]             out_c [CHANNEL_NUMBER];
  logic [MAX_ROUTERS_X_WIDTH-1:0]  tx;
  logic [MAX_ROUTERS_Y_WIDTH-1:0]  ty;
  logic [2:0]                      dir;
  logic [VC_WIDTH-1:0]             vc_base, vc_cand;
  logic                            unroutable, cand_free, in_ready_c, err_drop_c;
  int                              dx, dy;

  function automatic logic [CHANNEL_NUMBER_WIDTH-1:0] chan_idx(input logic [2:0] d,
                                                               input int unsigned v);
    return CHANNEL_NUMBER_WIDTH'(32'(d) * VC_NUM + v);
  endfunction

  assign in_bits = bus.in;
  assign tx      = bus.target_x;
  assign ty      = bus.target_y;
  assign sel_oh  = ChanOne << sel_q;

  // Dimension-ordered routing: X offset wins over Y offset.
  always_comb begin
    dx         = int'(tx) - int'(ROUTER_X);
    dy         = int'(ty) - int'(ROUTER_Y);
    unroutable = (int'(tx) >= int'(MAX_ROUTERS_X)) || (int'(ty) >= int'(MAX_ROUTERS_Y));
    if (dx > 0)      dir = DirEast;
    else if (dx < 0) dir = DirWest;
    else if (dy < 0) dir = DirNorth;
    else if (dy > 0) dir = DirSouth;
    else             dir = DirLocal;
  end

  // Adaptive mode scans VCs upward from vc_req with wrap and takes the first free one.
  always_comb begin
    vc_base   = (32'(bus.vc_req) < VC_NUM) ? bus.vc_req : '0;
    vc_cand   = vc_base;
    cand_free = 1'b0;
    if (VC_MODE == 0) begin
      cand_free = ~busy_q[chan_idx(dir, 32'(vc_base))];
    end else begin
      for (int unsigned k = 0; k < VC_NUM; k++) begin
        if (!cand_free && !busy_q[chan_idx(dir, (32'(vc_base) + k) % VC_NUM)]) begin
          cand_free = 1'b1;
          vc_cand   = VC_WIDTH'((32'(vc_base) + k) % VC_NUM);
        end
      end
    end
    cand    = chan_idx(dir, 32'(vc_cand));
    cand_oh = ChanOne << cand;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    busy_set    = '0;
    in_ready_c  = 1'b0;
    err_drop_c  = 1'b0;
    out_valid_c = '0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            if (bus.in.tid != ROUTING_HEADER) begin
              in_ready_c = 1'b1;
              err_drop_c = 1'b1;
            end else if (unroutable) begin
              in_ready_c = 1'b1;
              err_drop_c = 1'b1;
              if (!bus.in.tlast) state_d = StDrop;
            end else if (cand_free) begin
              out_valid_c = cand_oh;
              in_ready_c  = |(cand_oh & bus.out_ready);
              if (in_ready_c) begin
                busy_set = cand_oh;
                sel_d    = cand;
                if (!bus.in.tlast) state_d = StFwd;
              end
            end
          end
        end
        StFwd: begin
          out_valid_c = bus.in_valid ? sel_oh : '0;
          in_ready_c  = |(sel_oh & bus.out_ready);
          if (bus.in_valid && in_ready_c && bus.in.tlast) state_d = StIdle;
        end
        StDrop: begin
          in_ready_c = 1'b1;
          if (bus.in_valid && bus.in.tlast) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < int'(CHANNEL_NUMBER); i++) begin
      out_c[i] = out_valid_c[i] ? in_bits : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      // A new reservation overrides a coincident release.
      busy_q  <= (busy_q & ~bus.out_release) | busy_set;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_q;
  assign bus.err_drop  = err_drop_c;

  for (genvar g = 0; g < int'(CHANNEL_NUMBER); g++) begin : g_out
    assign bus.out[g] = out_c[g];
  end
endmodule

// File: tb/tb_algorithm_multi_vc.sv
// Scoreboard bench: dut_a is fixed-VC on a 4x4 mesh, dut_b adaptive on a 3-column mesh,
// both at router (1,1); one is driven at a time, selected by dsel.
module tb_algorithm_multi_vc;
  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tid;
    logic [3:0]  tdest;
    logic [3:0]  tuser;
    logic        tlast;
  } beat_t;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic        last;
  } exp_t;

  localparam logic [3:0] Hdr = 4'hF;

  logic        clk, rst, dsel, d_valid, cur_ready;
  beat_t       d_beat;
  logic [1:0]  d_tx, d_ty;
  logic        d_vc;
  logic [9:0]  d_ready, d_rel;
  int          n_cmp, n_fail, err_cnt, e0;
  exp_t        q [$];

  algorithm_multi_vc_if #(.MAX_ROUTERS_X(4)) ia ();
  algorithm_multi_vc_if #(.MAX_ROUTERS_X(3)) ib ();

  algorithm_multi_vc #(.VC_MODE(0), .MAX_ROUTERS_X(4), .ROUTER_X(1), .ROUTER_Y(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  algorithm_multi_vc #(.VC_MODE(1), .MAX_ROUTERS_X(3), .ROUTER_X(1), .ROUTER_Y(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  assign ia.in          = d_beat;
  assign ib.in          = d_beat;
  assign ia.in_valid    = d_valid & ~dsel;
  assign ib.in_valid    = d_valid & dsel;
  assign ia.target_x    = d_tx;
  assign ib.target_x    = d_tx;
  assign ia.target_y    = d_ty;
  assign ib.target_y    = d_ty;
  assign ia.vc_req      = d_vc;
  assign ib.vc_req      = d_vc;
  assign ia.out_ready   = d_ready;
  assign ib.out_ready   = d_ready;
  assign ia.out_release = dsel ? 10'h0 : d_rel;
  assign ib.out_release = dsel ? d_rel : 10'h0;
  assign cur_ready      = dsel ? ib.in_ready : ia.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input int ch, input logic [31:0] data, input logic hdr,
                           input logic last);
    bit done;
    done          = 1'b0;
    d_beat.tdata  = data;
    d_beat.tid    = hdr ? Hdr : 4'h0;
    d_beat.tdest  = 4'h0;
    d_beat.tuser  = 4'h0;
    d_beat.tlast  = last;
    d_valid       = 1'b1;
    if (ch >= 0) q.push_back('{ch, data, last});
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (cur_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: beat %h not accepted, expected acceptance", data);
    end
    d_valid = 1'b0;
  endtask

  // Routing sideband is scrambled after each header; a locked packet must ignore it.
  task automatic send_pkt(input int ch, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      send_beat(ch, base + b, b == 0, b == n - 1);
      if (b == 0) begin
        d_tx = ~d_tx;
        d_ty = ~d_ty;
        d_vc = ~d_vc;
      end
    end
  endtask

  task automatic present_header();
    d_beat       = '0;
    d_beat.tdata = 32'hDEAD;
    d_beat.tid   = Hdr;
    d_valid      = 1'b1;
  endtask

  task automatic pulse_rel(input logic [9:0] m);
    d_rel = m;
    @(posedge clk);
    #1;
    d_rel = '0;
  endtask

  logic [9:0]  ov;
  logic [31:0] od;
  logic        ol;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst) begin
      ov = dsel ? ib.out_valid : ia.out_valid;
      if (ov != 10'h0) begin
        n_cmp++;
        if ($countones(ov) != 1) begin
          n_fail++;
          $display("FAIL onehot: out_valid %b, expected a single bit", ov);
        end
      end
      for (int i = 0; i < 10; i++) begin
        if (ov[i]) begin
          n_cmp++;
          if (cur_ready !== d_ready[i]) begin
            n_fail++;
            $display("FAIL ready_mirror ch%0d: in_ready %b, expected %b", i, cur_ready,
                     d_ready[i]);
          end
          if (d_ready[i]) begin
            od = dsel ? ib.out[i].tdata : ia.out[i].tdata;
            ol = dsel ? ib.out[i].tlast : ia.out[i].tlast;
            n_cmp++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL sb_unexpected: ch%0d data %h, expected no beat", i, od);
            end else begin
              e = q.pop_front();
              if (e.ch != i || e.data !== od || e.last !== ol) begin
                n_fail++;
                $display("FAIL sb_beat: ch%0d data %h last %b, expected ch%0d data %h last %b",
                         i, od, ol, e.ch, e.data, e.last);
              end
            end
          end
        end
      end
      if (dsel ? ib.err_drop : ia.err_drop) err_cnt++;
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; err_cnt = 0;
    rst = 1'b1; dsel = 1'b0; d_valid = 1'b0; d_beat = '0;
    d_ready = '1; d_rel = '0; d_tx = 2'd0; d_ty = 2'd0; d_vc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    present_header();
    #1;
    check("rst_in_ready", int'(cur_ready), 0);
    check("rst_out_valid", int'(ia.out_valid), 0);
    check("rst_busy", int'(ia.busy), 0);
    d_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Local delivery, reservation and release.
    d_tx = 2'd1; d_ty = 2'd1; d_vc = 1'b0;
    send_pkt(0, 3, 32'h100);
    check("t1_busy", int'(ia.busy), 'h001);
    pulse_rel(10'h001);
    check("t1_release", int'(ia.busy), 0);

    // X resolved before Y.
    d_tx = 2'd3; d_ty = 2'd0; d_vc = 1'b0;
    send_pkt(4, 3, 32'h200);
    check("t2_busy", int'(ia.busy), 'h010);
    check("t2_no_err", err_cnt, 0);

    // Fixed VC waits on its busy channel instead of switching.
    d_tx = 2'd3; d_ty = 2'd0; d_vc = 1'b0;
    present_header();
    repeat (2) begin
      @(negedge clk);
      check("m0_stall_ready", int'(cur_ready), 0);
      check("m0_stall_valid", int'(ia.out_valid), 0);
    end
    @(posedge clk);
    #1;
    pulse_rel(10'h010);
    send_pkt(4, 2, 32'h300);
    check("m0_resume_busy", int'(ia.busy), 'h010);
    pulse_rel(10'h001);
    check("rel_nonbusy", int'(ia.busy), 'h010);
    pulse_rel(10'h010);

    // North single-beat header, then south on VC1.
    d_tx = 2'd1; d_ty = 2'd0; d_vc = 1'b0;
    send_pkt(2, 1, 32'h400);
    check("north_busy", int'(ia.busy), 'h004);
    d_tx = 2'd1; d_ty = 2'd3; d_vc = 1'b1;
    send_pkt(7, 2, 32'h410);
    check("south_busy", int'(ia.busy), 'h084);
    pulse_rel(10'h084);

    // West with backpressure pattern.
    d_tx = 2'd0; d_ty = 2'd1; d_vc = 1'b1;
    fork
      send_pkt(9, 5, 32'h500);
      begin
        logic [15:0] pat;
        pat = 16'b0110_1001_1100_0101;
        for (int k = 0; k < 16; k++) begin
          d_ready = pat[k] ? 10'h3FF : 10'h000;
          @(posedge clk);
          #1;
        end
        d_ready = '1;
      end
    join
    check("t4_busy", int'(ia.busy), 'h200);
    pulse_rel(10'h200);

    // Release mid-packet frees the reservation but keeps the lock.
    d_tx = 2'd1; d_ty = 2'd1; d_vc = 1'b1;
    fork
      send_pkt(1, 4, 32'h600);
      begin
        repeat (2) @(posedge clk);
        #1;
        d_rel = 10'h002;
        @(posedge clk);
        #1;
        d_rel = '0;
      end
    join
    check("fwd_release_busy", int'(ia.busy), 0);

    // Reset cuts a packet; leftovers arrive as strays.
    d_tx = 2'd1; d_ty = 2'd1; d_vc = 1'b0;
    send_beat(0, 32'h700, 1'b1, 1'b0);
    send_beat(0, 32'h701, 1'b0, 1'b0);
    d_beat.tdata = 32'h702; d_beat.tid = 4'h0; d_beat.tlast = 1'b0;
    d_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("t6_busy", int'(ia.busy), 0);
    check("t6_out_valid", int'(ia.out_valid), 0);
    check("t6_in_ready", int'(cur_ready), 0);
    e0 = err_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beat(-1, 32'h702, 1'b0, 1'b0);
    send_beat(-1, 32'h703, 1'b0, 1'b1);
    check("t6_stray_err", err_cnt - e0, 2);
    d_tx = 2'd1; d_ty = 2'd1; d_vc = 1'b0;
    send_pkt(0, 2, 32'h710);
    check("t6_next_busy", int'(ia.busy), 'h001);
    pulse_rel(10'h001);

    // Adaptive VC selection on dut_b.
    dsel = 1'b1;
    d_tx = 2'd2; d_ty = 2'd1; d_vc = 1'b0;
    send_pkt(4, 2, 32'h800);
    d_tx = 2'd2; d_ty = 2'd1; d_vc = 1'b0;
    send_pkt(5, 2, 32'h810);
    check("m1_busy", int'(ib.busy), 'h030);
    d_tx = 2'd2; d_ty = 2'd1; d_vc = 1'b0;
    present_header();
    repeat (2) begin
      @(negedge clk);
      check("m1_stall_ready", int'(cur_ready), 0);
      check("m1_stall_valid", int'(ib.out_valid), 0);
    end
    @(posedge clk);
    #1;
    pulse_rel(10'h010);
    send_pkt(4, 2, 32'h820);
    check("m1_resume_busy", int'(ib.busy), 'h030);
    pulse_rel(10'h030);
    check("m1_release", int'(ib.busy), 0);

    // Unroutable packet and a lone stray beat.
    e0 = err_cnt;
    d_tx = 2'd3; d_ty = 2'd0; d_vc = 1'b0;
    send_pkt(-1, 4, 32'h900);
    check("t5_drop_err", err_cnt - e0, 1);
    check("t5_drop_busy", int'(ib.busy), 0);
    e0 = err_cnt;
    send_beat(-1, 32'h910, 1'b0, 1'b1);
    check("t5_stray_err", err_cnt - e0, 1);
    d_tx = 2'd2; d_ty = 2'd1; d_vc = 1'b1;
    send_pkt(5, 1, 32'h920);
    check("t5_next_busy", int'(ib.busy), 'h020);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/algorithm_multi_vc.md
Name: algorithm_multi_vc

Overview:
- Successor to the dual-channel routing stage. It steers one input AXI-Stream packet stream to one of 5 directions × VC_NUM virtual channels using dimension-ordered XY routing.
- The output channel is locked for the whole packet, so target changes mid-packet are ignored.
- Reserved channels are held until the downstream stage returns a release pulse.
- VC choice is either fixed by a request input or adaptive (first free VC).
- Sits between the input FIFO and the crossbar arbiters of each router port.

Parameters:
- DATA_WIDTH, 32, TDATA width of axis_data_t
- ID_WIDTH, 4, TID width
- DEST_WIDTH, 4, TDEST width
- USER_WIDTH, 4, TUSER width
- VC_NUM, 2, virtual channels per direction (≥1)
- VC_WIDTH, max(1,$clog2(VC_NUM)), VC index width
- CHANNEL_NUMBER, 5*VC_NUM, total output channels
- CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER), channel index width
- VC_MODE, 0, 0 = fixed VC from vc_req; 1 = adaptive
- MAX_ROUTERS_X, 4, mesh columns
- MAX_ROUTERS_X_WIDTH, $clog2(MAX_ROUTERS_X), target_x width
- MAX_ROUTERS_Y, 4, mesh rows
- MAX_ROUTERS_Y_WIDTH, $clog2(MAX_ROUTERS_Y), target_y width
- ROUTER_X, 0, own column
- ROUTER_Y, 0, own row

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in  in  axis_data_t  input beat (TID, TLAST used)
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- out  out  axis_data_t[CHANNEL_NUMBER]  per-channel beat
- out_valid  out  1[CHANNEL_NUMBER]  per-channel valid
- out_ready  in  1[CHANNEL_NUMBER]  per-channel ready
- out_release  in  1[CHANNEL_NUMBER]  downstream pulse freeing a reserved channel
- vc_req  in  VC_WIDTH  requested VC, sampled with header
- target_x  in  MAX_ROUTERS_X_WIDTH  destination column, valid with header
- target_y  in  MAX_ROUTERS_Y_WIDTH  destination row, valid with header
- busy  out  CHANNEL_NUMBER  reservation flags
- err_drop  out  1  one-cycle pulse when a packet or stray beat is discarded

Behaviour:
- Channel index = dir*VC_NUM + vc.
- Directions: 0 local, 1 north (ty<RY), 2 east (tx>RX), 3 south (ty>RY), 4 west (tx<RX).
- XY routing: X is resolved first (east/west). Otherwise Y (north/south). Otherwise local.
- Unroutable: tx ≥ MAX_ROUTERS_X or ty ≥ MAX_ROUTERS_Y.
- Datapath is zero-latency combinational, in → out[sel].
  - Only out_valid[sel] may be high. All other out_valid = 0; unselected out = '0.
  - in_ready = out_ready[sel] while forwarding.
- FSM states: IDLE, FWD, DROP.
- IDLE, with in_valid and TID == ROUTING_HEADER:
  - Compute dir and candidate VC.
    - VC_MODE 0: vc = vc_req.
    - VC_MODE 1: first non-busy VC of dir, scanning upward from vc_req with wrap; none free → stall.
  - If the candidate is busy: in_ready = 0 and out_valid all 0; re-evaluate every cycle.
  - If the candidate is free: drive it. On handshake, register sel, set busy[sel], go to FWD (stay in IDLE if TLAST).
  - If unroutable: in_ready = 1, err_drop pulses on the header. Go to DROP unless TLAST.
- IDLE, non-header beat: consumed (in_ready = 1), err_drop pulses, no output.
- FWD: beats go to the registered sel only; target_x/target_y/vc_req ignored. TLAST handshake → IDLE.
- DROP: in_ready = 1, beats discarded; TLAST handshake → IDLE.
- busy[i]:
  - Set on header handshake to channel i.
  - Cleared by an out_release[i] pulse; release on a non-busy channel is ignored.
  - Release during FWD on the same channel clears busy but not the packet lock.
  - A set and release on the same channel in the same cycle cannot legally occur; set wins.
- Reset (any time, including mid-packet):
  - state = IDLE, busy = '0, err_drop = 0.
  - While rst is high, all out_valid = 0 and in_ready = 0.
  - A packet cut by reset is truncated; its remaining beats arrive in IDLE as stray beats and are dropped.

Test Plan:
1. RX=1, RY=1, VC_NUM=2, mode 0. Header tx=1, ty=1, vc_req=0, 3-beat packet → out[0] carries 3 beats and busy[0]=1 after the header. busy[0] clears the cycle after an out_release[0] pulse.
2. Header tx=3, ty=0 → east channel 4 (XY: X first); north channels 2/3 stay idle. Toggling target_y mid-packet → no reroute.
3. Mode 1, busy[4]=1, east header with vc_req=0 → goes to channel 5. With busy[4]=busy[5]=1 → in_ready=0 stall; after out_release[4], header accepted on channel 4 next cycle.
4. Random out_ready stalls mid-packet → in_ready mirrors out_ready[sel]; beat order and count are exact with no duplicates.
5. MAX_ROUTERS_X=3 with header tx=3 → 4-beat packet fully consumed, no out_valid, err_drop pulses once. A lone non-header beat in IDLE → dropped, err_drop pulses.
6. Assert rst during beat 2 of 4 → busy=0, all out_valid=0. After release, remaining stray beats are dropped; the next header routes normally.
